// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------------------------
// uart_rx - asynchronous serial receiver (8N1, optionally 8E1) with a one-entry holding register.
//
// The serial line is brought into the i_clk domain through a two-flop synchronizer. All framing
// logic works on the synchronized copy only. A start bit is recognised on a 1->0 transition of
// the synchronized line, confirmed at its middle, and every following bit is sampled one bit
// period later. A completed byte is handed to a holding register with a valid/ready handshake.
//
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit between the eighth
// data bit and the stop bit. Without the macro the frame is plain 8N1 and no parity logic exists.
//
// Parameters:
//   CLKS_PER_BIT  i_clk cycles per UART bit, legal range 4..65535 (default 868 = 100 MHz/115200)
//
// Ports:
//   i_clk        clock, all state changes on its rising edge
//   i_rst        asynchronous active-low reset
//   rx           serial input, idle high
//   o_data       received byte, valid while o_valid is high
//   o_valid      holding register full
//   i_ready      consumer takes o_data when o_valid & i_ready at a rising edge
//   o_frame_err  one-cycle pulse: stop bit sampled low (or parity mismatch when enabled)
//   o_overrun    one-cycle pulse: a good byte was dropped because the holding register was full
// ---------------------------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    // Counter compare points. The start bit is confirmed half a bit after the edge; data and
    // parity bits are sampled a full bit period apart, which lands them mid-bit.
    localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] BitEnd   = 16'(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop
`ifdef UART_RX_PARITY_EN
        ,
        StParity
`endif
    } state_e;

    // Synchronizer and edge detector.
    logic       rx_meta_q;
    logic       rx_s_q;
    logic       rx_prev_q;

    // Frame timing and assembly.
    state_e     state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic       stop_q, stop_d;
`ifdef UART_RX_PARITY_EN
    logic       par_err_q, par_err_d;
`endif

    // Holding register and status pulses.
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

    // Frame completion strobes.
    logic       frame_end;
    logic       frame_ok;
    logic       accept;

    // -----------------------------------------------------------------------------------------
    // Synchronizer. Reset to the idle level so a reset never looks like a start edge.
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Frame FSM: next-state logic.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        stop_d    = stop_q;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        frame_end = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                // A true falling edge is required, so a line still held low after a break
                // frame is ignored until it has gone back high.
                if (rx_prev_q && !rx_s_q) begin
                    state_d = StStart;
                end
            end

            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    // High at mid start bit means it was a glitch: drop it silently.
                    state_d = rx_s_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == BitLast) begin
                    cnt_d     = '0;
                    // Even parity: data plus parity bit must hold an even number of ones.
                    par_err_d = ^{shift_q, rx_s_q};
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif

            StStop: begin
                // The stop bit is captured at mid-bit; the verdict is acted on one edge later,
                // which is also when the FSM drops back to idle.
                if (cnt_q == BitLast) begin
                    stop_d = rx_s_q;
                    cnt_d  = cnt_q + 16'd1;
                end else if (cnt_q == BitEnd) begin
                    frame_end = 1'b1;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Holding register, overrun and framing-error pulses.
    // -----------------------------------------------------------------------------------------
    always_comb begin
`ifdef UART_RX_PARITY_EN
        frame_ok = frame_end && stop_q && !par_err_q;
`else
        frame_ok = frame_end && stop_q;
`endif
        accept      = valid_q && i_ready;

        data_d      = data_q;
        valid_d     = valid_q;
        // Bad stop and bad parity share one pulse per frame.
        frame_err_d = frame_end && !frame_ok;
        overrun_d   = 1'b0;

        if (accept) begin
            valid_d = 1'b0;
        end

        if (frame_ok) begin
            // A byte may load in the same cycle the previous one is taken.
            if (!valid_q || accept) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // State registers.
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            stop_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            stop_q      <= stop_d;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------------------------
// tb_uart_rx - directed self-checking bench for uart_rx at CLKS_PER_BIT = 16.
//
// Frames are driven one bit period per CPB clocks, changing the line 1 time unit after a rising
// edge. A negedge monitor logs pulses, o_valid rises and accepted bytes; each scenario task clears
// the log, drives its stimulus and compares the log against hand-computed values.
//
// Latency from the edge after which the start bit is driven to the edge on which o_valid rises:
//   2 (synchronizer) + 1 (edge detect) + CPB/2 (mid start) + 8*CPB (data) + CPB (stop)
//   + 1 (delivery edge)  [+ CPB with UART_RX_PARITY_EN]
// i.e. o_valid rises 17 cycles after the FSM enters its stop-bit interval.
// ---------------------------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 3 + CPB / 2 + 10 * CPB + 1;
`else
    localparam int LAT = 3 + CPB / 2 + 9 * CPB + 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_err;
    logic       o_overrun;

    int n_checks;
    int n_pass;
    int cyc;
    int start_cyc;
    int fe_cnt;
    int ov_cnt;
    int rise_cnt;
    int rise_cyc;
    logic [7:0] acc_data;
    logic       valid_prev;
`ifdef UART_RX_PARITY_EN
    logic       par_flip;
`endif

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .rx         (rx),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_frame_err) fe_cnt = fe_cnt + 1;
            if (o_overrun) ov_cnt = ov_cnt + 1;
            if (o_valid && !valid_prev) begin
                rise_cnt = rise_cnt + 1;
                rise_cyc = cyc;
            end
            if (o_valid && i_ready) acc_data = o_data;
            valid_prev = o_valid;
        end else begin
            valid_prev = 1'b0;
        end
    end

    task automatic clear_log();
        fe_cnt   = 0;
        ov_cnt   = 0;
        rise_cnt = 0;
        rise_cyc = 0;
        acc_data = 8'hxx;
    endtask

    // Drives one complete frame plus one idle bit period of high line.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        @(posedge clk);
        #1;
        rx        = 1'b0;
        start_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1;
            rx = d[i];
        end
`ifdef UART_RX_PARITY_EN
        repeat (CPB) @(posedge clk);
        #1;
        rx = (^d) ^ par_flip;
`endif
        repeat (CPB) @(posedge clk);
        #1;
        rx = stop_bit;
        repeat (CPB) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        rx      = 1'b1;
        i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else n_pass++;
        n_checks++; if (o_data !== 8'h00) $display("FAIL reset_data: got %h want 00", o_data); else n_pass++;
        n_checks++; if (o_frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", o_frame_err); else n_pass++;
        n_checks++; if (o_overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", o_overrun); else n_pass++;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        clear_log();
        i_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        n_checks++; if (rise_cnt !== 1) $display("FAIL basic_rises: got %0d want 1", rise_cnt); else n_pass++;
        n_checks++; if (acc_data !== 8'hA5) $display("FAIL basic_data: got %h want a5", acc_data); else n_pass++;
        n_checks++; if (rise_cyc - start_cyc !== LAT) $display("FAIL basic_latency: got %0d want %0d", rise_cyc - start_cyc, LAT); else n_pass++;
        n_checks++; if (fe_cnt !== 0) $display("FAIL basic_ferr: got %0d want 0", fe_cnt); else n_pass++;
        n_checks++; if (ov_cnt !== 0) $display("FAIL basic_ovr: got %0d want 0", ov_cnt); else n_pass++;
        n_checks++; if (o_valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", o_valid); else n_pass++;
    endtask

    task automatic test_glitch();
        clear_log();
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        n_checks++; if (rise_cnt !== 0) $display("FAIL glitch_valid: got %0d want 0", rise_cnt); else n_pass++;
        n_checks++; if (fe_cnt + ov_cnt !== 0) $display("FAIL glitch_flags: got %0d want 0", fe_cnt + ov_cnt); else n_pass++;
        // Back in idle: the next frame is timed from its own start edge.
        send_frame(8'h5A, 1'b1);
        n_checks++; if (acc_data !== 8'h5A) $display("FAIL glitch_next_data: got %h want 5a", acc_data); else n_pass++;
        n_checks++; if (rise_cyc - start_cyc !== LAT) $display("FAIL glitch_next_latency: got %0d want %0d", rise_cyc - start_cyc, LAT); else n_pass++;
    endtask

    task automatic test_frame_err();
        clear_log();
        send_frame(8'h3C, 1'b0);
        n_checks++; if (fe_cnt !== 1) $display("FAIL ferr_pulse_cycles: got %0d want 1", fe_cnt); else n_pass++;
        n_checks++; if (rise_cnt !== 0) $display("FAIL ferr_valid: got %0d want 0", rise_cnt); else n_pass++;
        clear_log();
        send_frame(8'h81, 1'b1);
        n_checks++; if (acc_data !== 8'h81) $display("FAIL ferr_next_data: got %h want 81", acc_data); else n_pass++;
        n_checks++; if (fe_cnt !== 0) $display("FAIL ferr_next_ferr: got %0d want 0", fe_cnt); else n_pass++;
    endtask

    task automatic test_break();
        clear_log();
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (14 * CPB) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        n_checks++; if (fe_cnt !== 1) $display("FAIL break_ferr: got %0d want 1", fe_cnt); else n_pass++;
        n_checks++; if (rise_cnt !== 0) $display("FAIL break_valid: got %0d want 0", rise_cnt); else n_pass++;
        clear_log();
        send_frame(8'hC3, 1'b1);
        n_checks++; if (acc_data !== 8'hC3) $display("FAIL break_next_data: got %h want c3", acc_data); else n_pass++;
        n_checks++; if (rise_cnt !== 1) $display("FAIL break_next_rises: got %0d want 1", rise_cnt); else n_pass++;
    endtask

    task automatic test_overrun();
        clear_log();
        i_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        n_checks++; if (o_valid !== 1'b1) $display("FAIL ovr_valid_held: got %b want 1", o_valid); else n_pass++;
        n_checks++; if (o_data !== 8'h11) $display("FAIL ovr_data_held: got %h want 11", o_data); else n_pass++;
        n_checks++; if (ov_cnt !== 1) $display("FAIL ovr_pulse_cycles: got %0d want 1", ov_cnt); else n_pass++;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (acc_data !== 8'h11) $display("FAIL ovr_accepted: got %h want 11", acc_data); else n_pass++;
        n_checks++; if (o_valid !== 1'b0) $display("FAIL ovr_valid_clear: got %b want 0", o_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_log();
        i_ready = 1'b0;
        send_frame(8'h55, 1'b1);
        n_checks++; if (o_data !== 8'h55) $display("FAIL b2b_first: got %h want 55", o_data); else n_pass++;
        fork
            send_frame(8'hAA, 1'b1);
            begin
                // Raise i_ready for exactly the cycle ending on the delivery edge of 8'hAA.
                #2;
                repeat (LAT) @(posedge clk);
                #1;
                i_ready = 1'b1;
                @(posedge clk);
                #1;
                i_ready = 1'b0;
            end
        join
        n_checks++; if (o_data !== 8'hAA) $display("FAIL b2b_data: got %h want aa", o_data); else n_pass++;
        n_checks++; if (o_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", o_valid); else n_pass++;
        n_checks++; if (ov_cnt !== 0) $display("FAIL b2b_ovr: got %0d want 0", ov_cnt); else n_pass++;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        clear_log();
        fork
            send_frame(8'hF0, 1'b1);
            begin
                // Middle of data bit 4.
                #2;
                repeat (5 * CPB + CPB / 2 + 1) @(posedge clk);
                #1;
                rst_n = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        join
        n_checks++; if (rise_cnt + fe_cnt + ov_cnt !== 0) $display("FAIL rstmid_partial: got %0d want 0", rise_cnt + fe_cnt + ov_cnt); else n_pass++;
        send_frame(8'h0F, 1'b1);
        n_checks++; if (rise_cnt !== 1) $display("FAIL rstmid_rises: got %0d want 1", rise_cnt); else n_pass++;
        n_checks++; if (acc_data !== 8'h0F) $display("FAIL rstmid_data: got %h want 0f", acc_data); else n_pass++;
        n_checks++; if (fe_cnt + ov_cnt !== 0) $display("FAIL rstmid_flags: got %0d want 0", fe_cnt + ov_cnt); else n_pass++;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_log();
        par_flip = 1'b1;
        // 8'h07 has three ones, so a parity bit of 0 is wrong.
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        n_checks++; if (fe_cnt !== 1) $display("FAIL par_ferr: got %0d want 1", fe_cnt); else n_pass++;
        n_checks++; if (rise_cnt !== 0) $display("FAIL par_valid: got %0d want 0", rise_cnt); else n_pass++;
        clear_log();
        send_frame(8'h07, 1'b1);
        n_checks++; if (acc_data !== 8'h07) $display("FAIL par_good_data: got %h want 07", acc_data); else n_pass++;
        n_checks++; if (fe_cnt !== 0) $display("FAIL par_good_ferr: got %0d want 0", fe_cnt); else n_pass++;
    endtask
`endif

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        cyc        = 0;
        start_cyc  = 0;
        valid_prev = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_flip   = 1'b0;
`endif
        clear_log();
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_break();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
